// File: rtl/atm_keypad_entry_if.sv
// Keypad strobes, auth handshake and credential outputs of the ATM keypad front end.
interface atm_keypad_entry_if;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        auth_done;
   logic        auth_ok;
   logic [11:0] accNumber;
   logic [3:0]  pin;
   logic        req_valid;
   logic        session;
   logic        locked;
   logic        err;
   logic        timeout;
   logic [1:0]  fail_cnt;

   // Environment side: keypad and authentication stage.
   modport master (
      output key_valid, key_code, auth_done, auth_ok,
      input  accNumber, pin, req_valid, session, locked, err, timeout, fail_cnt
   );

   // Keypad front end.
   modport slave (
      input  key_valid, key_code, auth_done, auth_ok,
      output accNumber, pin, req_valid, session, locked, err, timeout, fail_cnt
   );
endinterface

// File: rtl/atm_keypad_entry.sv
// ATM keypad front end: assembles account number and PIN, requests authentication,
// and owns failed-attempt lockout and inactivity timeout. All outputs are registered.
module atm_keypad_entry #(
   parameter int unsigned ACC_DIGITS     = 4,
   parameter int unsigned MAX_ATTEMPTS   = 3,
   parameter int unsigned TIMEOUT_CYCLES = 100,
   parameter int unsigned LOCK_CYCLES    = 200
) (
   input logic               clk,
   input logic               rst,
   atm_keypad_entry_if.slave bus
);

   localparam int unsigned CntW  = $clog2(ACC_DIGITS + 1);
   localparam int unsigned TmrW  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned LockW = $clog2(LOCK_CYCLES + 1);

   localparam logic [3:0] KeyClear  = 4'hA;
   localparam logic [3:0] KeyEnter  = 4'hB;
   localparam logic [3:0] KeyCancel = 4'hC;

   typedef enum logic [2:0] {
      StAccEntry,
      StPinEntry,
      StWaitAuth,
      StSession,
      StLocked
   } state_e;

   state_e           state_q, state_d;
   logic [13:0]      acc_acc_q, acc_acc_d;
   logic [CntW-1:0]  acc_cnt_q, acc_cnt_d;
   logic [11:0]      acc_num_q, acc_num_d;
   logic [3:0]       pin_reg_q, pin_reg_d;
   logic             pin_has_q, pin_has_d;
   logic [3:0]       pin_q, pin_d;
   logic [1:0]       fail_q, fail_d;
   logic [TmrW-1:0]  timer_q, timer_d;
   logic [LockW-1:0] lock_q, lock_d;
   logic             err_q, err_d;
   logic             tmo_q, tmo_d;
   logic             req_valid_q, session_q, locked_q;

   logic       is_digit;
   logic       key_cancel;
   logic       running;
   logic       tmo_hit;
   logic [1:0] fail_inc;

   assign is_digit   = bus.key_code <= 4'd9;
   assign key_cancel = bus.key_valid && (bus.key_code == KeyCancel);
   assign fail_inc   = fail_q + 2'd1;

   // Idle timer only runs while a transaction is in progress.
   assign running = (state_q == StPinEntry) || (state_q == StWaitAuth) ||
                    (state_q == StSession)  ||
                    ((state_q == StAccEntry) && (acc_cnt_q != '0));
   // Expiry on the edge where the idle count would reach TIMEOUT_CYCLES; a key resets it.
   assign tmo_hit = running && !bus.key_valid && (timer_q == TmrW'(TIMEOUT_CYCLES - 1));

   // Next-state, field updates, error/timeout pulses and timers.
   always_comb begin
      state_d   = state_q;
      acc_acc_d = acc_acc_q;
      acc_cnt_d = acc_cnt_q;
      acc_num_d = acc_num_q;
      pin_reg_d = pin_reg_q;
      pin_has_d = pin_has_q;
      pin_d     = pin_q;
      fail_d    = fail_q;
      lock_d    = '0;
      err_d     = 1'b0;
      tmo_d     = 1'b0;

      // Cancel and timeout abandon everything except the failure count, and take
      // priority over a same-cycle auth result.
      if ((state_q != StLocked) && (key_cancel || tmo_hit)) begin
         state_d   = StAccEntry;
         acc_acc_d = '0;
         acc_cnt_d = '0;
         acc_num_d = '0;
         pin_reg_d = '0;
         pin_has_d = 1'b0;
         pin_d     = '0;
         tmo_d     = tmo_hit;
      end else begin
         unique case (state_q)
            StAccEntry: begin
               if (bus.key_valid) begin
                  if (is_digit) begin
                     if (acc_cnt_q == CntW'(ACC_DIGITS)) begin
                        err_d = 1'b1;
                     end else begin
                        acc_acc_d = acc_acc_q * 14'd10 + 14'(bus.key_code);
                        acc_cnt_d = acc_cnt_q + CntW'(1);
                     end
                  end else if (bus.key_code == KeyClear) begin
                     acc_acc_d = '0;
                     acc_cnt_d = '0;
                  end else if (bus.key_code == KeyEnter) begin
                     acc_acc_d = '0;
                     acc_cnt_d = '0;
                     if ((acc_cnt_q == '0) || (acc_acc_q > 14'd4095)) begin
                        err_d = 1'b1;
                     end else begin
                        acc_num_d = acc_acc_q[11:0];
                        state_d   = StPinEntry;
                     end
                  end
               end
            end

            StPinEntry: begin
               if (bus.key_valid) begin
                  if (is_digit) begin
                     if (pin_has_q) begin
                        err_d = 1'b1;
                     end else begin
                        pin_reg_d = bus.key_code;
                        pin_has_d = 1'b1;
                     end
                  end else if (bus.key_code == KeyClear) begin
                     pin_reg_d = '0;
                     pin_has_d = 1'b0;
                  end else if (bus.key_code == KeyEnter) begin
                     if (!pin_has_q) begin
                        err_d = 1'b1;
                     end else begin
                        pin_d     = pin_reg_q;
                        pin_reg_d = '0;
                        pin_has_d = 1'b0;
                        state_d   = StWaitAuth;
                     end
                  end
               end
            end

            StWaitAuth: begin
               if (bus.auth_done) begin
                  if (bus.auth_ok) begin
                     fail_d  = '0;
                     state_d = StSession;
                  end else begin
                     fail_d = fail_inc;
                     pin_d  = '0;
                     if (32'(fail_inc) == MAX_ATTEMPTS) begin
                        state_d = StLocked;
                     end else begin
                        state_d = StPinEntry;
                     end
                  end
               end
            end

            StSession: begin
            end

            StLocked: begin
               if (lock_q == LockW'(LOCK_CYCLES - 1)) begin
                  state_d   = StAccEntry;
                  fail_d    = '0;
                  acc_acc_d = '0;
                  acc_cnt_d = '0;
                  acc_num_d = '0;
                  pin_reg_d = '0;
                  pin_has_d = 1'b0;
                  pin_d     = '0;
               end else begin
                  lock_d = lock_q + LockW'(1);
               end
            end

            default: begin
               state_d = StAccEntry;
            end
         endcase
      end

      if (bus.key_valid || (state_d != state_q) || tmo_hit || !running) begin
         timer_d = '0;
      end else if (timer_q != TmrW'(TIMEOUT_CYCLES)) begin
         timer_d = timer_q + TmrW'(1);
      end else begin
         timer_d = timer_q;
      end
   end

   // State and registered outputs; status flags decode the next state so they align with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StAccEntry;
         acc_acc_q   <= '0;
         acc_cnt_q   <= '0;
         acc_num_q   <= '0;
         pin_reg_q   <= '0;
         pin_has_q   <= 1'b0;
         pin_q       <= '0;
         fail_q      <= '0;
         timer_q     <= '0;
         lock_q      <= '0;
         err_q       <= 1'b0;
         tmo_q       <= 1'b0;
         req_valid_q <= 1'b0;
         session_q   <= 1'b0;
         locked_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_acc_q   <= acc_acc_d;
         acc_cnt_q   <= acc_cnt_d;
         acc_num_q   <= acc_num_d;
         pin_reg_q   <= pin_reg_d;
         pin_has_q   <= pin_has_d;
         pin_q       <= pin_d;
         fail_q      <= fail_d;
         timer_q     <= timer_d;
         lock_q      <= lock_d;
         err_q       <= err_d;
         tmo_q       <= tmo_d;
         req_valid_q <= (state_d == StWaitAuth);
         session_q   <= (state_d == StSession);
         locked_q    <= (state_d == StLocked);
      end
   end

   assign bus.accNumber = acc_num_q;
   assign bus.pin       = pin_q;
   assign bus.req_valid = req_valid_q;
   assign bus.session   = session_q;
   assign bus.locked    = locked_q;
   assign bus.err       = err_q;
   assign bus.timeout   = tmo_q;
   assign bus.fail_cnt  = fail_q;

endmodule
